// File: rtl/pia_6821.sv
// pia_6821: two-port peripheral interface adapter, 6821-style register model.
// Each port (A/B) is an identical pia_port instance; the only difference is
// what fires the C2 strobe (read of ORA for port A, write of ORB for port B).

module pia_port #(
    parameter bit HS_ON_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rw,
    input  logic       sel,
    input  logic       rs,
    input  logic [7:0] data_in,
    input  logic [7:0] p_i,
    input  logic       c1,
    input  logic       c2_i,
    output logic [7:0] rd_data,
    output logic [7:0] p_o,
    output logic [7:0] p_oe,
    output logic       irq,
    output logic       c2_o,
    output logic       c2_oe
);

    logic [7:0] or_r;
    logic [7:0] ddr_r;
    logic [5:0] cr_r;
    logic       irq1;
    logic       irq2;
    logic       c1_d;
    logic       c2_d;
    logic       c2_hs;

    logic or_sel;
    logic ddr_sel;
    logic cr_sel;
    logic wr;
    logic rd;
    logic c1_edge;
    logic c2_edge;
    logic flag_clr;
    logic strobe_mode;
    logic trig;

    // Register decode: the data slot maps to OR or DDR depending on CR[2].
    assign or_sel   = sel & ~rs & cr_r[2];
    assign ddr_sel  = sel & ~rs & ~cr_r[2];
    assign cr_sel   = sel & rs;
    assign wr       = cs & ~rw;
    assign rd       = cs & rw;
    assign flag_clr = rd & or_sel;

    // Edge polarity selected by CR[1] for C1 and CR[4] for C2.
    assign c1_edge = cr_r[1] ? (~c1_d & c1) : (c1_d & ~c1);
    assign c2_edge = cr_r[4] ? (~c2_d & c2_i) : (c2_d & ~c2_i);

    // Handshake/pulse modes: C2 is an output with CR[4]=0.
    assign strobe_mode = cr_r[5] & ~cr_r[4];
    assign trig        = HS_ON_WRITE ? (wr & or_sel) : (rd & or_sel);

    // Host-writable registers; CR writes only reach bits [5:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_r  <= 8'h00;
            ddr_r <= 8'h00;
            cr_r  <= 6'h00;
        end else if (wr) begin
            if (or_sel)  or_r  <= data_in;
            if (ddr_sel) ddr_r <= data_in;
            if (cr_sel)  cr_r  <= data_in[5:0];
        end
    end

    // Edge history and interrupt flags; a same-cycle set beats a read-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_d <= 1'b0;
            c2_d <= 1'b0;
            irq1 <= 1'b0;
            irq2 <= 1'b0;
        end else begin
            c1_d <= c1;
            c2_d <= c2_i;
            if (c1_edge)       irq1 <= 1'b1;
            else if (flag_clr) irq1 <= 1'b0;
            if (cr_r[5])       irq2 <= 1'b0;
            else if (c2_edge)  irq2 <= 1'b1;
            else if (flag_clr) irq2 <= 1'b0;
        end
    end

    // C2 strobe state: low on trigger, back high after one clk (pulse) or on C1 edge (handshake).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c2_hs <= 1'b1;
        end else if (!strobe_mode) begin
            c2_hs <= 1'b1;
        end else if (trig) begin
            c2_hs <= 1'b0;
        end else if (cr_r[3]) begin
            c2_hs <= 1'b1;
        end else if (c1_edge) begin
            c2_hs <= 1'b1;
        end
    end

    // Read mux for this port's two address slots.
    always_comb begin
        rd_data = ddr_r;
        if (rs)
            rd_data = {irq1, irq2, cr_r};
        else if (cr_r[2])
            rd_data = (or_r & ddr_r) | (p_i & ~ddr_r);
    end

    // C2 pin drive: input mode floats high, manual follows CR[3], else strobe state.
    always_comb begin
        c2_oe = cr_r[5];
        c2_o  = 1'b1;
        if (cr_r[5])
            c2_o = cr_r[4] ? cr_r[3] : c2_hs;
    end

    assign p_o  = or_r;
    assign p_oe = ddr_r;
    assign irq  = (irq1 & cr_r[0]) | (irq2 & cr_r[3] & ~cr_r[5]);

endmodule

module pia_6821 (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irqa,
    output logic       irqb,
    input  logic [7:0] pa_i,
    output logic [7:0] pa_o,
    output logic [7:0] pa_oe,
    input  logic       ca1,
    input  logic       ca2_i,
    output logic       ca2_o,
    output logic       ca2_oe,
    input  logic [7:0] pb_i,
    output logic [7:0] pb_o,
    output logic [7:0] pb_oe,
    input  logic       cb1,
    input  logic       cb2_i,
    output logic       cb2_o,
    output logic       cb2_oe
);

    logic [1:0][7:0] p_i;
    logic [1:0][7:0] p_o;
    logic [1:0][7:0] p_oe;
    logic [1:0][7:0] rd_data;
    logic [1:0]      c1;
    logic [1:0]      c2_i;
    logic [1:0]      c2_o;
    logic [1:0]      c2_oe;
    logic [1:0]      irq;

    assign p_i  = {pb_i, pa_i};
    assign c1   = {cb1, ca1};
    assign c2_i = {cb2_i, ca2_i};

    // Port 0 = A (strobe on ORA read), port 1 = B (strobe on ORB write).
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_port
            pia_port #(
                .HS_ON_WRITE(g == 1)
            ) u_port (
                .clk     (clk),
                .rst     (rst),
                .cs      (cs),
                .rw      (rw),
                .sel     (addr[1] == 1'(g)),
                .rs      (addr[0]),
                .data_in (data_in),
                .p_i     (p_i[g]),
                .c1      (c1[g]),
                .c2_i    (c2_i[g]),
                .rd_data (rd_data[g]),
                .p_o     (p_o[g]),
                .p_oe    (p_oe[g]),
                .irq     (irq[g]),
                .c2_o    (c2_o[g]),
                .c2_oe   (c2_oe[g])
            );
        end
    endgenerate

    assign data_out = rd_data[addr[1]];
    assign irqa     = irq[0];
    assign irqb     = irq[1];
    assign pa_o     = p_o[0];
    assign pa_oe    = p_oe[0];
    assign pb_o     = p_o[1];
    assign pb_oe    = p_oe[1];
    assign ca2_o    = c2_o[0];
    assign ca2_oe   = c2_oe[0];
    assign cb2_o    = c2_o[1];
    assign cb2_oe   = c2_oe[1];

endmodule

// File: tb/tb_pia_6821.sv
// tb_pia_6821: directed vectors with hand-computed expectations for pia_6821.

module tb_pia_6821;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irqa;
    logic       irqb;
    logic [7:0] pa_i;
    logic [7:0] pa_o;
    logic [7:0] pa_oe;
    logic       ca1;
    logic       ca2_i;
    logic       ca2_o;
    logic       ca2_oe;
    logic [7:0] pb_i;
    logic [7:0] pb_o;
    logic [7:0] pb_oe;
    logic       cb1;
    logic       cb2_i;
    logic       cb2_o;
    logic       cb2_oe;

    int nvec = 0;
    int nerr = 0;

    pia_6821 dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irqa     (irqa),
        .irqb     (irqb),
        .pa_i     (pa_i),
        .pa_o     (pa_o),
        .pa_oe    (pa_oe),
        .ca1      (ca1),
        .ca2_i    (ca2_i),
        .ca2_o    (ca2_o),
        .ca2_oe   (ca2_oe),
        .pb_i     (pb_i),
        .pb_o     (pb_o),
        .pb_oe    (pb_oe),
        .cb1      (cb1),
        .cb2_i    (cb2_i),
        .cb2_o    (cb2_o),
        .cb2_oe   (cb2_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0;
        #1;
    endtask

    task automatic peek(input logic [1:0] a, input string tag, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; rw = 1'b1; addr = 2'd0; data_in = 8'h00;
        pa_i = 8'h00; pb_i = 8'h00;
        ca1 = 1'b1; ca2_i = 1'b1; cb1 = 1'b1; cb2_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_pa_o", pa_o, 8'h00);
        chk("rst_pa_oe", pa_oe, 8'h00);
        chk("rst_pb_o", pb_o, 8'h00);
        chk("rst_pb_oe", pb_oe, 8'h00);
        chk("rst_ca2", {6'd0, ca2_oe, ca2_o}, 8'h01);
        chk("rst_cb2", {6'd0, cb2_oe, cb2_o}, 8'h01);
        chk("rst_irq", {6'd0, irqb, irqa}, 8'h00);
        peek(2'd0, "rst_dout0", 8'h00);
        tick();

        // port A output path
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'h04);
        wr(2'd0, 8'h5A);
        chk("pa_o", pa_o, 8'h5A);
        chk("pa_oe", pa_oe, 8'hFF);
        peek(2'd0, "ora_rd", 8'h5A);
        peek(2'd1, "cra_rd", 8'h04);

        // port B mixed direction read
        wr(2'd2, 8'h0F);
        wr(2'd3, 8'h04);
        wr(2'd2, 8'hA5);
        pb_i = 8'h3C;
        peek(2'd2, "orb_mix", 8'h35);
        peek(2'd0, "ddr_b_indep", 8'h5A);

        // CA1 falling edge -> IRQA1
        wr(2'd1, 8'h01);
        ca1 = 1'b0;
        tick();
        chk("ca1_fall_irq", {7'd0, irqa}, 8'h01);
        peek(2'd1, "cra_flag", 8'h81);
        rd(2'd0);
        chk("ddr_rd_noclr", {7'd0, irqa}, 8'h01);
        wr(2'd1, 8'h05);
        chk("crwr_keep", {7'd0, irqa}, 8'h01);
        rd(2'd0);
        chk("ora_rd_clr", {7'd0, irqa}, 8'h00);
        peek(2'd1, "cra_after_clr", 8'h05);

        // CA1 rising mode
        ca1 = 1'b1;
        tick();
        chk("rise_in_fall_mode", {7'd0, irqa}, 8'h00);
        wr(2'd1, 8'h07);
        ca1 = 1'b0;
        tick();
        chk("fall_in_rise_mode", {7'd0, irqa}, 8'h00);
        ca1 = 1'b1;
        tick();
        chk("rise_in_rise_mode", {7'd0, irqa}, 8'h01);
        rd(2'd0);
        chk("clr2", {7'd0, irqa}, 8'h00);

        // pending flag with irq disabled, then enabled
        wr(2'd1, 8'h04);
        ca1 = 1'b0;
        tick();
        chk("masked_irq", {7'd0, irqa}, 8'h00);
        peek(2'd1, "masked_flag", 8'h84);
        wr(2'd1, 8'h05);
        chk("enable_pending", {7'd0, irqa}, 8'h01);
        rd(2'd0);

        // set beats read-clear in the same clk
        ca1 = 1'b1;
        tick();
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = 2'd0; ca1 = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        #1;
        chk("set_wins", {7'd0, irqa}, 8'h01);
        rd(2'd0);
        chk("clr3", {7'd0, irqa}, 8'h00);

        // CA2 input falling edge -> IRQA2
        wr(2'd1, 8'h0D);
        ca2_i = 1'b0;
        tick();
        chk("ca2_irq", {7'd0, irqa}, 8'h01);
        peek(2'd1, "ca2_flag", 8'h4D);
        rd(2'd0);
        chk("ca2_clr", {7'd0, irqa}, 8'h00);
        ca2_i = 1'b1;

        // CA2 manual output
        wr(2'd1, 8'h38);
        chk("ca2_man1", {6'd0, ca2_oe, ca2_o}, 8'h03);
        wr(2'd1, 8'h30);
        chk("ca2_man0", {6'd0, ca2_oe, ca2_o}, 8'h02);
        wr(2'd1, 8'h00);
        chk("ca2_input", {6'd0, ca2_oe, ca2_o}, 8'h01);

        // CA2 handshake on ORA read, released by CA1 falling edge
        ca1 = 1'b1;
        tick();
        wr(2'd1, 8'h24);
        chk("ca2_hs_idle", {7'd0, ca2_o}, 8'h01);
        rd(2'd0);
        chk("ca2_hs_low", {7'd0, ca2_o}, 8'h00);
        tick();
        chk("ca2_hs_hold", {7'd0, ca2_o}, 8'h00);
        ca1 = 1'b0;
        tick();
        chk("ca2_hs_rel", {7'd0, ca2_o}, 8'h01);

        // CB2 pulse on ORB write
        wr(2'd3, 8'h2C);
        chk("cb2_pulse_idle", {6'd0, cb2_oe, cb2_o}, 8'h03);
        wr(2'd2, 8'h77);
        chk("cb2_pulse_low", {7'd0, cb2_o}, 8'h00);
        chk("pb_o_77", pb_o, 8'h77);
        tick();
        chk("cb2_pulse_high", {7'd0, cb2_o}, 8'h01);

        // CB2 handshake on ORB write
        wr(2'd3, 8'h24);
        wr(2'd2, 8'h11);
        chk("cb2_hs_low", {7'd0, cb2_o}, 8'h00);
        repeat (3) tick();
        chk("cb2_hs_hold", {7'd0, cb2_o}, 8'h00);
        cb1 = 1'b0;
        tick();
        chk("cb2_hs_rel", {7'd0, cb2_o}, 8'h01);

        // both ports: pending flags from the handshake edges, then simultaneous edges
        ca1 = 1'b1; cb1 = 1'b1;
        tick();
        wr(2'd1, 8'h05);
        chk("irqa_pending", {7'd0, irqa}, 8'h01);
        rd(2'd0);
        wr(2'd3, 8'h05);
        chk("irqb_pending", {7'd0, irqb}, 8'h01);
        rd(2'd2);
        chk("both_clr", {6'd0, irqb, irqa}, 8'h00);
        ca1 = 1'b0; cb1 = 1'b0;
        tick();
        chk("both_irq", {6'd0, irqb, irqa}, 8'h03);
        peek(2'd1, "cra_both", 8'h85);
        peek(2'd3, "crb_both", 8'h85);

        // reset with flags pending and a CR write in flight
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 2'd1; data_in = 8'hFF;
        rst = 1'b1;
        #1;
        chk("rst_irq_now", {6'd0, irqb, irqa}, 8'h00);
        chk("rst_pa_oe2", pa_oe, 8'h00);
        chk("rst_pb_o2", pb_o, 8'h00);
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
        rst = 1'b0;
        #1;
        peek(2'd1, "rst_cra", 8'h00);
        peek(2'd3, "rst_crb", 8'h00);
        peek(2'd2, "rst_ddrb", 8'h00);
        chk("rst_c2", {4'd0, cb2_oe, cb2_o, ca2_oe, ca2_o}, 8'h05);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pia_6821.md
PIA_6821 -- requirements
Module: pia_6821

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cs  in  1  one-clk access strobe; qualifies read side effects and writes.
REQ-005 rw  in  1  1=read, 0=write.
REQ-006 addr  in  2  register select.
REQ-007 data_in  in  8  write data.
REQ-008 data_out  out  8  read data.
REQ-009 irqa  out  1  port A interrupt, active-high.
REQ-010 irqb  out  1  port B interrupt, active-high.
REQ-011 pa_i  in  8  port A pin inputs.
REQ-012 pa_o  out  8  port A output register (ORA).
REQ-013 pa_oe  out  8  port A direction register (DDRA); 1=output.
REQ-014 ca1  in  1  port A control input 1.
REQ-015 ca2_i  in  1  CA2 pin input.
REQ-016 ca2_o  out  1  CA2 output value.
REQ-017 ca2_oe  out  1  CA2 output enable.
REQ-018 pb_i, pb_o, pb_oe, cb1, cb2_i, cb2_o, cb2_oe SHALL mirror the port A ports (same direction and width) for port B.

Function
REQ-019 addr map: 0 = ORA if CRA[2] else DDRA; 1 = CRA; 2 = ORB if CRB[2] else DDRB; 3 = CRB.
REQ-020 Write when cs & ~rw: data_in goes to the selected register; CR write affects bits [5:0] only, and bits [7:6] are read-only flags.
REQ-021 data_out is combinational from addr and ignores cs. Port read = (ORx & DDRx) | (px_i & ~DDRx). DDR read = DDRx. CR read = {IRQx1, IRQx2, CRx[5:0]}.
REQ-022 Read of ORA/ORB with cs & rw & CRx[2] clears IRQx1 and IRQx2 at that clk edge.
REQ-023 C1 edge: C1 is registered every clk. An active edge is falling when CR[1]=0 and rising when CR[1]=1. An active edge sets IRQx1.
REQ-024 C2 input mode (CR[5]=0): active edge is falling when CR[4]=0 and rising when CR[4]=1, taken on cx2_i. An active edge sets IRQx2. cx2_oe=0 and cx2_o=1.
REQ-025 C2 output mode (CR[5]=1): cx2_oe=1 and IRQx2 is held clear.
- CR[4]=1: cx2_o = CR[3] (manual).
- CR[4]=0, CR[3]=0, handshake: CA2 goes low on a cs read of ORA, and CB2 goes low on a cs write of ORB. The output returns high on the next active C1 edge.
- CR[4]=0, CR[3]=1, pulse: the same trigger drives the output low for exactly one clk, then high.
REQ-026 irqx = (IRQx1 & CR[0]) | (IRQx2 & CR[3] & ~CR[5]).
REQ-027 Flag set and read-clear in the same clk: set wins.
REQ-028 Writes to CR never change the flags. Enabling CR[0] while a flag is pending asserts irq immediately (combinational).
REQ-029 Ports A and B are fully independent, and simultaneous events on both are handled in the same clk.

Reset
REQ-030 rst=1 asynchronously clears ORA, DDRA, CRA, ORB, DDRB, CRB, all flags and the edge history.
REQ-031 After reset: pa_o=pb_o=0, pa_oe=pb_oe=0, ca2_o=cb2_o=1, ca2_oe=cb2_oe=0, irqa=irqb=0, data_out = DDRA content (0) at addr 0.
REQ-032 Reset asserted mid-access aborts that access with no register update.

Verification
REQ-033 Write DDRA=FF (addr0), CRA=04, ORA=5A -> pa_o=5A, pa_oe=FF; read addr0 -> 5A.
REQ-034 DDRB=0F, CRB=04, ORB=A5, pb_i=3C -> read addr2 = 35.
REQ-035 CRA=01, ca1 1->0 -> irqa=1 and read of CRA bit7=1; cs read of addr0 -> irqa=0 next clk. With CRA=03 a falling edge sets no flag, and a rising edge sets the flag.
REQ-036 CRA=38 -> ca2_o=1, ca2_oe=1; CRA=30 -> ca2_o=0; CRA=00 -> ca2_oe=0.
REQ-037 CRB=2C (pulse mode), write ORB -> cb2_o low for exactly one clk. CRB=24 (handshake), write ORB -> cb2_o low until a falling cb1 edge.
REQ-038 Flag pending and rst pulse -> flags clear, irq=0 immediately, all registers 00.
